// File: rtl/sram_access_sequencer_pkg.sv
// Shared types and constants for the SRAM access sequencer.
package sram_seq_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned DEF_RD_WAIT = 2;
   localparam int unsigned DEF_WR_WAIT = 2;
endpackage

// File: rtl/sram_access_sequencer_if.sv
// Host handshake plus SRAM wrapper pins of the access sequencer.
interface sram_access_sequencer_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 16
);
   logic              iREQ;
   logic              iWR;
   logic [ADDR_W-1:0] iADDR;
   logic [DATA_W-1:0] iDATA;
   logic [1:0]        iBE_N;
   logic              oACK;
   logic [DATA_W-1:0] oRDATA;
   logic              oBUSY;
   logic [ADDR_W-1:0] oSR_ADDR;
   logic [DATA_W-1:0] oSR_DATA;
   logic [DATA_W-1:0] iSR_DATA;
   logic [1:0]        oSR_BE_N;
   logic              oSR_CE_N;
   logic              oSR_OE_N;
   logic              oSR_WE_N;

   modport master (
      output iREQ, iWR, iADDR, iDATA, iBE_N, iSR_DATA,
      input  oACK, oRDATA, oBUSY, oSR_ADDR, oSR_DATA, oSR_BE_N,
             oSR_CE_N, oSR_OE_N, oSR_WE_N
   );

   modport slave (
      input  iREQ, iWR, iADDR, iDATA, iBE_N, iSR_DATA,
      output oACK, oRDATA, oBUSY, oSR_ADDR, oSR_DATA, oSR_BE_N,
             oSR_CE_N, oSR_OE_N, oSR_WE_N
   );
endinterface

// File: rtl/sram_access_sequencer.sv
// Turns a single-cycle host request into a SETUP/ACCESS/HOLD strobe sequence
// for an asynchronous 16-bit SRAM; every output is a register.
module sram_access_sequencer
   import sram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W  = 18,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RD_WAIT = DEF_RD_WAIT,
   parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
   input logic                    iCLK,
   input logic                    iRST_N,
   sram_access_sequencer_if.slave bus
);

   if (RD_WAIT < 1 || RD_WAIT > (2**CNT_W) - 1) begin : g_bad_rd_wait
      $fatal(1, "RD_WAIT must be in 1..15");
   end
   if (WR_WAIT < 1 || WR_WAIT > (2**CNT_W) - 1) begin : g_bad_wr_wait
      $fatal(1, "WR_WAIT must be in 1..15");
   end

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              wr, wr_d;
   logic [ADDR_W-1:0] addr, addr_d;
   logic [DATA_W-1:0] wdata, wdata_d;
   logic [1:0]        be_n, be_n_d;
   logic [DATA_W-1:0] rdata, rdata_d;
   logic              ce_n, ce_n_d;
   logic              oe_n, oe_n_d;
   logic              we_n, we_n_d;
   logic              ack, ack_d;
   logic              busy, busy_d;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      wr_d    = wr;
      addr_d  = addr;
      wdata_d = wdata;
      be_n_d  = be_n;
      rdata_d = rdata;
      unique case (state)
         IDLE: begin
            if (bus.iREQ) begin
               state_d = SETUP;
               wr_d    = bus.iWR;
               addr_d  = bus.iADDR;
               wdata_d = bus.iDATA;
               be_n_d  = bus.iBE_N;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = wr ? WR_LOAD : RD_LOAD;
         end
         ACCESS: begin
            if (cnt == '0) begin
               state_d = HOLD;
               if (!wr) rdata_d = bus.iSR_DATA;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state so they are registered
      // and change exactly at the state transitions.
      ce_n_d = (state_d == IDLE);
      oe_n_d = !((state_d == ACCESS) && !wr_d);
      we_n_d = !((state_d == ACCESS) && wr_d);
      ack_d  = (state_d == HOLD);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state <= IDLE;
         cnt   <= '0;
         wr    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         be_n  <= '1;
         rdata <= '0;
         ce_n  <= 1'b1;
         oe_n  <= 1'b1;
         we_n  <= 1'b1;
         ack   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         wr    <= wr_d;
         addr  <= addr_d;
         wdata <= wdata_d;
         be_n  <= be_n_d;
         rdata <= rdata_d;
         ce_n  <= ce_n_d;
         oe_n  <= oe_n_d;
         we_n  <= we_n_d;
         ack   <= ack_d;
         busy  <= busy_d;
      end
   end

   assign bus.oSR_ADDR = addr;
   assign bus.oSR_DATA = wdata;
   assign bus.oSR_BE_N = be_n;
   assign bus.oSR_CE_N = ce_n;
   assign bus.oSR_OE_N = oe_n;
   assign bus.oSR_WE_N = we_n;
   assign bus.oACK     = ack;
   assign bus.oBUSY    = busy;
   assign bus.oRDATA   = rdata;

endmodule
